// File: rtl/_and_pkg.sv
// Shared types and elaboration-time helpers for the AND-stage qualifier.
package _and_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CONFIRM_HI = 2'd1,
        ST_HIGH       = 2'd2,
        ST_CONFIRM_LO = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/_sync_delay.sv
// Input delay chain of STAGES flops; a zero-stage build is a plain wire.
module _sync_delay #(
    parameter int STAGES = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_q      = i_d;
        end else begin : g_chain
            logic [STAGES-1:0] r_chain;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_chain <= '0;
                end else begin
                    for (int i = STAGES - 1; i > 0; i--) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                    r_chain[0] <= i_d;
                end
            end

            assign o_q = r_chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/_and_qualifier.sv
// Debounces the AND-stage result into a qualified level with hold/release
// hysteresis, one-cycle edge pulses and a saturating rise-event counter.
module _and_qualifier
    import _and_pkg::*;
#(
    parameter int SYNC_STAGES    = 0,
    parameter int HOLD_CYCLES    = 4,
    parameter int RELEASE_CYCLES = 2,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   andIn,
    input  logic                   clearCount,
    output logic                   qualified,
    output logic                   risePulse,
    output logic                   fallPulse,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] eventCount,
    output logic [1:0]             dbgState
);

    localparam int RUN_W = clog2(max2(HOLD_CYCLES, RELEASE_CYCLES)) + 1;
    localparam logic [RUN_W-1:0] HOLD_LAST = RUN_W'(HOLD_CYCLES - 1);
    localparam logic [RUN_W-1:0] REL_LAST  = RUN_W'(RELEASE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

    logic                   w_sample;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RUN_W-1:0]       r_run;
    logic [RUN_W-1:0]       w_run_nxt;
    logic                   r_qualified;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_qual_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   w_busy_nxt;

    _sync_delay #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (clock),
        .i_rst (reset),
        .i_d   (andIn),
        .o_q   (w_sample)
    );

    // A hold/release length of one skips the matching confirm state entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sample) begin
                        if (HOLD_CYCLES == 1) begin
                            w_state_nxt = ST_HIGH;
                            w_run_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_CONFIRM_HI;
                            w_run_nxt   = RUN_ONE;
                        end
                    end
                end
                ST_CONFIRM_HI: begin
                    if (!w_sample) begin
                        w_state_nxt = ST_IDLE;
                        w_run_nxt   = '0;
                    end else if (r_run == HOLD_LAST) begin
                        w_state_nxt = ST_HIGH;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = r_run + RUN_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!w_sample) begin
                        if (RELEASE_CYCLES == 1) begin
                            w_state_nxt = ST_IDLE;
                            w_run_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_CONFIRM_LO;
                            w_run_nxt   = RUN_ONE;
                        end
                    end
                end
                ST_CONFIRM_LO: begin
                    if (w_sample) begin
                        w_state_nxt = ST_HIGH;
                        w_run_nxt   = '0;
                    end else if (r_run == REL_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = r_run + RUN_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    // Dropping enable forces idle silently, hence the enable term on the fall edge.
    assign w_qual_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_CONFIRM_LO);
    assign w_rise_nxt = w_qual_nxt && !r_qualified;
    assign w_fall_nxt = enable && !w_qual_nxt && r_qualified;
    assign w_busy_nxt = (w_state_nxt == ST_CONFIRM_HI) || (w_state_nxt == ST_CONFIRM_LO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_run       <= '0;
            r_qualified <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_qualified <= w_qual_nxt;
            r_rise      <= w_rise_nxt;
            r_fall      <= w_fall_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clearCount) begin
            r_count <= '0;
        end else if (w_rise_nxt && (r_count != {COUNT_WIDTH{1'b1}})) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign qualified  = r_qualified;
    assign risePulse  = r_rise;
    assign fallPulse  = r_fall;
    assign busy       = r_busy;
    assign eventCount = r_count;
    assign dbgState   = r_state;

endmodule

// File: tb/tb__and_qualifier.sv
// Directed bench for _and_qualifier: three instances cover S=0/H=4/R=2 with a
// 2-bit counter, the H=1/R=1 shortcut, and S=2 with enable abort and async reset.
module tb__and_qualifier;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       andIn;
    logic       clearCount;
    logic       en2;
    logic       a2;
    logic       clr2;

    logic       q0, r0, f0, b0;
    logic [1:0] c0;
    logic [1:0] s0;
    logic       q1, r1, f1, b1;
    logic [7:0] c1;
    logic [1:0] s1;
    logic       q2, r2, f2, b2;
    logic [7:0] c2;
    logic [1:0] s2;

    int checks;
    int errors;

    _and_qualifier #(
        .SYNC_STAGES(0), .HOLD_CYCLES(4), .RELEASE_CYCLES(2), .COUNT_WIDTH(2)
    ) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .andIn(andIn),
        .clearCount(clearCount), .qualified(q0), .risePulse(r0), .fallPulse(f0),
        .busy(b0), .eventCount(c0), .dbgState(s0)
    );

    _and_qualifier #(
        .SYNC_STAGES(0), .HOLD_CYCLES(1), .RELEASE_CYCLES(1), .COUNT_WIDTH(8)
    ) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .andIn(andIn),
        .clearCount(clearCount), .qualified(q1), .risePulse(r1), .fallPulse(f1),
        .busy(b1), .eventCount(c1), .dbgState(s1)
    );

    _and_qualifier #(
        .SYNC_STAGES(2), .HOLD_CYCLES(4), .RELEASE_CYCLES(2), .COUNT_WIDTH(8)
    ) dut2 (
        .clock(clock), .reset(reset), .enable(en2), .andIn(a2),
        .clearCount(clr2), .qualified(q2), .risePulse(r2), .fallPulse(f2),
        .busy(b2), .eventCount(c2), .dbgState(s2)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_sat [4];
        exp_sat = '{2'd2, 2'd3, 2'd3, 2'd3};
        checks     = 0;
        errors     = 0;
        clock      = 1'b0;
        reset      = 1'b1;
        enable     = 1'b1;
        andIn      = 1'b1;
        clearCount = 1'b0;
        en2        = 1'b1;
        a2         = 1'b0;
        clr2       = 1'b0;

        // 1: reset held with andIn high
        repeat (3) step();
        chk("rst_qual", q0, 0);
        chk("rst_rise", r0, 0);
        chk("rst_fall", f0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_count", c0, 0);
        chk("rst_state", s0, 0);
        chk("rst_qual_h1", q1, 0);
        chk("rst_qual_s2", q2, 0);

        andIn = 1'b0;
        reset = 1'b0;
        repeat (2) step();
        chk("idle_qual", q0, 0);

        // 2: four high samples qualify; H=1 instance qualifies at once
        andIn = 1'b1;
        step();
        chk("h1_rise", r1, 1);
        chk("h1_qual", q1, 1);
        chk("h1_count", c1, 1);
        chk("hold_c1_qual", q0, 0);
        chk("hold_c1_busy", b0, 1);
        step();
        chk("h1_rise_gone", r1, 0);
        step();
        chk("hold_c3_qual", q0, 0);
        step();
        chk("hold_c4_qual", q0, 1);
        chk("hold_c4_rise", r0, 1);
        chk("hold_c4_count", c0, 1);
        chk("hold_c4_busy", b0, 0);
        chk("hold_c4_state", s0, 2);
        step();
        chk("high_rise_gone", r0, 0);
        chk("high_qual", q0, 1);

        // 4: single low sample is absorbed, two lows release
        andIn = 1'b0;
        step();
        chk("rel_lo1_qual", q0, 1);
        chk("rel_lo1_fall", f0, 0);
        chk("rel_lo1_busy", b0, 1);
        chk("r1_fall", f1, 1);
        chk("r1_qual", q1, 0);
        andIn = 1'b1;
        step();
        chk("rel_back_qual", q0, 1);
        chk("rel_back_rise", r0, 0);
        chk("rel_back_fall", f0, 0);
        chk("h1_rerise", r1, 1);
        chk("h1_count2", c1, 2);
        andIn = 1'b0;
        step();
        chk("rel_a_qual", q0, 1);
        step();
        chk("rel_b_qual", q0, 0);
        chk("rel_b_fall", f0, 1);
        chk("rel_b_rise", r0, 0);
        step();
        chk("rel_fall_gone", f0, 0);
        chk("rel_count", c0, 1);

        // 3: three-cycle glitch never qualifies
        andIn = 1'b1;
        step();
        chk("gl_busy1", b0, 1);
        chk("gl_state1", s0, 1);
        step();
        chk("gl_busy2", b0, 1);
        step();
        chk("gl_busy3", b0, 1);
        chk("gl_qual3", q0, 0);
        andIn = 1'b0;
        step();
        chk("gl_busy_end", b0, 0);
        chk("gl_qual_end", q0, 0);
        chk("gl_rise_end", r0, 0);
        chk("gl_count", c0, 1);

        // 5: 2-bit counter saturates, then clear wins over a rise
        for (int k = 0; k < 4; k++) begin
            andIn = 1'b1;
            repeat (4) step();
            chk("sat_rise", r0, 1);
            chk("sat_count", c0, exp_sat[k]);
            andIn = 1'b0;
            repeat (2) step();
        end
        andIn = 1'b1;
        repeat (3) step();
        clearCount = 1'b1;
        step();
        chk("clr_rise", r0, 1);
        chk("clr_count", c0, 0);
        clearCount = 1'b0;
        step();
        chk("clr_hold", c0, 0);
        andIn = 1'b0;
        repeat (2) step();

        // 6: S=2 adds two cycles of latency
        a2 = 1'b1;
        repeat (5) step();
        chk("s2_c5_qual", q2, 0);
        step();
        chk("s2_c6_qual", q2, 1);
        chk("s2_c6_rise", r2, 1);
        chk("s2_count", c2, 1);
        en2 = 1'b0;
        step();
        chk("en_qual", q2, 0);
        chk("en_fall", f2, 0);
        chk("en_rise", r2, 0);
        chk("en_count", c2, 1);
        chk("en_state", s2, 0);
        clr2 = 1'b1;
        step();
        chk("en_clr", c2, 0);
        clr2 = 1'b0;
        en2  = 1'b1;
        step();
        chk("ab_busy", b2, 1);
        chk("ab_state", s2, 1);
        reset = 1'b1;
        #1;
        chk("ab_busy_rst", b2, 0);
        chk("ab_state_rst", s2, 0);
        chk("ab_qual_rst", q2, 0);
        chk("ab_fall_rst", f2, 0);
        a2 = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_state", s2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
